hand_bbox_extractor: RTL and testbench
======================================

// Module: hand_bbox_extractor
// PURPOSE
//  Sits directly downstream of the skin/background segmentation stage and consumes its 1-bit per-pixel
//  object mask (raster order, 160x120 default). Accumulates per-frame hand features: bounding box,
//  object pixel count (area) and a presence flag. Emits one feature record per complete frame for the
//  downstream gesture classifier.
// PARAMETERS
//  IMG_WIDTH   160  pixels per line
//  IMG_HEIGHT  120  lines per frame
//  MIN_AREA    200  minimum object pixel count for hand_present=1
// PORTS
//  clk            in   1   system clock, all logic on rising edge
//  rst            in   1   asynchronous, active-high reset
//  object_image   in   1   segmented pixel, 1 = object/skin
//  pixel_valid    in   1   object_image valid this cycle; low = stall, nothing advances
//  frame_start    in   1   qualifies the current valid pixel as (0,0) of a new frame
//  feat_valid     out  1   one-cycle pulse: feature outputs updated
//  frame_abort    out  1   one-cycle pulse: frame_start seen before previous frame completed
//  hand_present   out  1   area >= MIN_AREA
//  min_x, max_x   out  8   bounding box columns (clog2(IMG_WIDTH))
//  min_y, max_y   out  7   bounding box rows (clog2(IMG_HEIGHT))
//  area           out  15  object pixel count (clog2(IMG_WIDTH*IMG_HEIGHT+1))
//  sum_x, sum_y   out  22  first-moment sums (centroid feature, see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; x/y counters, accumulators and all outputs 0.
//  - FSM IDLE: pixels ignored until pixel_valid && frame_start; that pixel is accumulated as (0,0) -> ACCUM.
//  - FSM ACCUM: each pixel_valid advances x; at x=IMG_WIDTH-1, x wraps to 0 and y increments.
//    object_image=1 updates min/max x/y, area+1, sum_x+=x, sum_y+=y.
//  - Accumulator init per frame: min_* all ones, max_*/area/sums 0; first object pixel loads both min and max.
//  - Frame end: on the edge accepting pixel (IMG_WIDTH-1,IMG_HEIGHT-1), the output registers load the
//    final values (including that pixel), feat_valid=1 for that next cycle only, and FSM -> IDLE.
//    Latency = 1 cycle after the last pixel. Outputs hold until the next feat_valid.
//  - Empty frame (area=0): min/max outputs reported as 0, hand_present=0.
//  - frame_start in ACCUM (not on the last pixel): frame_abort pulses 1 cycle, no feat_valid, old outputs
//    held, accumulators re-initialised with the current pixel as (0,0), remain in ACCUM.
//  - frame_start on the last pixel of a frame: frame completes normally; the pixel is not a new (0,0).
//  - frame_start with pixel_valid=0: ignored.
//  - Reset mid-frame: asynchronous clear of everything; the partial frame is discarded.
//  - No overflow possible: widths sized for IMG_WIDTH*IMG_HEIGHT worst case.
// CONFIGURATION
//  - Macro HAND_CENTROID_EN defined: sum_x/sum_y accumulators built and reported at feat_valid.
//  - Not defined: no sum accumulators synthesised; sum_x/sum_y tied to 0. Other outputs are unchanged.
// STRUCTURE
//  - Package hand_feat_pkg: IMG_WIDTH/IMG_HEIGHT defaults, X_W/Y_W/AREA_W/SUM_W widths, and the FSM
//    state encoding (IDLE=0, ACCUM=1).
//  - Sub-module raster_position_counter: x/y counters with pixel_valid enable, frame_start restart,
//    and last_pixel flag. Shared with later raster stages.
// TESTING
//  1. All-zero frame -> feat_valid one pulse, area=0, hand_present=0, bbox outputs all 0.
//  2. Single 1 at (10,5) -> min_x=max_x=10, min_y=max_y=5, area=1, hand_present=0.
//  3. Rectangle x40..59, y30..49 -> bbox 40/59/30/49, area=400, hand_present=1;
//     with HAND_CENTROID_EN: sum_x=19800, sum_y=15800; without: both 0.
//  4. Test 3 with random pixel_valid gaps (about 30% low) -> identical results; feat_valid exactly 1 cycle
//     after the last valid pixel.
//  5. frame_start at pixel 5000 of a frame, then a full test-2 frame -> frame_abort pulses once,
//     only one feat_valid, and it carries the test-2 values.
//  6. rst asserted mid-frame -> outputs 0 immediately (async) and IDLE; pixels without frame_start ignored.

Source files
------------

// File: rtl/hand_feat_pkg.sv
// Shared geometry, field widths and FSM encoding for the hand feature extraction stages.
// Widths are sized for the default frame so no accumulator can overflow.
package hand_feat_pkg;

    localparam int DEFAULT_IMG_WIDTH  = 160;
    localparam int DEFAULT_IMG_HEIGHT = 120;
    localparam int DEFAULT_MIN_AREA   = 200;

    localparam int X_W    = $clog2(DEFAULT_IMG_WIDTH);
    localparam int Y_W    = $clog2(DEFAULT_IMG_HEIGHT);
    localparam int AREA_W = $clog2(DEFAULT_IMG_WIDTH * DEFAULT_IMG_HEIGHT + 1);
    // A moment sum is bounded by area * max coordinate.
    localparam int SUM_W  = AREA_W + X_W - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/raster_position_counter.sv
// Raster x/y position of the pixel presented this cycle; advances on each accepted pixel.
// restart treats the current pixel as (0,0); last_pixel reflects the stored position only.
module raster_position_counter
    import hand_feat_pkg::*;
#(
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           advance,
    input  logic           restart,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last_pixel
);

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;

    assign x          = restart ? '0 : x_q;
    assign y          = restart ? '0 : y_q;
    assign last_pixel = (x_q == X_W'(IMG_WIDTH - 1)) && (y_q == Y_W'(IMG_HEIGHT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (advance) begin
            if (x == X_W'(IMG_WIDTH - 1)) begin
                x_q <= '0;
                y_q <= (y == Y_W'(IMG_HEIGHT - 1)) ? '0 : y + Y_W'(1);
            end else begin
                x_q <= x + X_W'(1);
                y_q <= y;
            end
        end
    end

endmodule

// File: rtl/hand_bbox_extractor.sv
// Per-frame bounding box, area and presence from a 1-bit raster mask; record 1 cycle after last pixel.
// pixel_valid low stalls all state (no backpressure); HAND_CENTROID_EN adds the sum_x/sum_y moments.
module hand_bbox_extractor
    import hand_feat_pkg::*;
#(
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
    parameter int MIN_AREA   = DEFAULT_MIN_AREA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              object_image,
    input  logic              pixel_valid,
    input  logic              frame_start,
    output logic              feat_valid,
    output logic              frame_abort,
    output logic              hand_present,
    output logic [X_W-1:0]    min_x,
    output logic [X_W-1:0]    max_x,
    output logic [Y_W-1:0]    min_y,
    output logic [Y_W-1:0]    max_y,
    output logic [AREA_W-1:0] area,
    output logic [SUM_W-1:0]  sum_x,
    output logic [SUM_W-1:0]  sum_y
);

    state_t state_q, state_d;

    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic              last_pixel;
    logic              start_pix, frame_done, abort, acc_en;

    logic [X_W-1:0]    acc_min_x, acc_max_x, base_min_x, base_max_x, nxt_min_x, nxt_max_x;
    logic [Y_W-1:0]    acc_min_y, acc_max_y, base_min_y, base_max_y, nxt_min_y, nxt_max_y;
    logic [AREA_W-1:0] acc_area, base_area, nxt_area;

    // A frame_start on the closing pixel belongs to the finishing frame, not a new one.
    assign start_pix  = pixel_valid && frame_start && ((state_q == IDLE) || !last_pixel);
    assign frame_done = pixel_valid && (state_q == ACCUM) && last_pixel;
    assign abort      = start_pix && (state_q == ACCUM);
    assign acc_en     = start_pix || (pixel_valid && (state_q == ACCUM));

    raster_position_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .advance    (acc_en),
        .restart    (start_pix),
        .x          (cur_x),
        .y          (cur_y),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_pix)  state_d = ACCUM;
            ACCUM:   if (frame_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        base_min_x = acc_min_x;
        base_max_x = acc_max_x;
        base_min_y = acc_min_y;
        base_max_y = acc_max_y;
        base_area  = acc_area;
        if (start_pix) begin
            base_min_x = '1;
            base_max_x = '0;
            base_min_y = '1;
            base_max_y = '0;
            base_area  = '0;
        end
        nxt_min_x = base_min_x;
        nxt_max_x = base_max_x;
        nxt_min_y = base_min_y;
        nxt_max_y = base_max_y;
        nxt_area  = base_area;
        if (object_image) begin
            if (cur_x < base_min_x) nxt_min_x = cur_x;
            if (cur_x > base_max_x) nxt_max_x = cur_x;
            if (cur_y < base_min_y) nxt_min_y = cur_y;
            if (cur_y > base_max_y) nxt_max_y = cur_y;
            nxt_area = base_area + AREA_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_min_x <= '1;
            acc_max_x <= '0;
            acc_min_y <= '1;
            acc_max_y <= '0;
            acc_area  <= '0;
        end else if (acc_en) begin
            acc_min_x <= nxt_min_x;
            acc_max_x <= nxt_max_x;
            acc_min_y <= nxt_min_y;
            acc_max_y <= nxt_max_y;
            acc_area  <= nxt_area;
        end
    end

    // An empty frame leaves min_* at all ones; report the box as zeros instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feat_valid   <= 1'b0;
            frame_abort  <= 1'b0;
            hand_present <= 1'b0;
            min_x        <= '0;
            max_x        <= '0;
            min_y        <= '0;
            max_y        <= '0;
            area         <= '0;
        end else begin
            feat_valid  <= frame_done;
            frame_abort <= abort;
            if (frame_done) begin
                hand_present <= (nxt_area >= AREA_W'(MIN_AREA));
                min_x        <= (nxt_area == '0) ? '0 : nxt_min_x;
                max_x        <= nxt_max_x;
                min_y        <= (nxt_area == '0) ? '0 : nxt_min_y;
                max_y        <= nxt_max_y;
                area         <= nxt_area;
            end
        end
    end

`ifdef HAND_CENTROID_EN
    logic [SUM_W-1:0] acc_sum_x, acc_sum_y, nxt_sum_x, nxt_sum_y;

    always_comb begin
        nxt_sum_x = start_pix ? '0 : acc_sum_x;
        nxt_sum_y = start_pix ? '0 : acc_sum_y;
        if (object_image) begin
            nxt_sum_x = nxt_sum_x + SUM_W'(cur_x);
            nxt_sum_y = nxt_sum_y + SUM_W'(cur_y);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_sum_x <= '0;
            acc_sum_y <= '0;
            sum_x     <= '0;
            sum_y     <= '0;
        end else begin
            if (acc_en) begin
                acc_sum_x <= nxt_sum_x;
                acc_sum_y <= nxt_sum_y;
            end
            if (frame_done) begin
                sum_x <= nxt_sum_x;
                sum_y <= nxt_sum_y;
            end
        end
    end
`else
    assign sum_x = '0;
    assign sum_y = '0;
`endif

endmodule

// File: tb/tb_hand_bbox_extractor.sv
// Directed frames with hand-computed feature records, plus abort and mid-frame reset sequences.
// Frame height is reduced to 52 lines to keep the run short; every test region still fits.
module tb_hand_bbox_extractor;

    localparam int W = 160;
    localparam int H = 52;
    localparam int N = W * H;
`ifdef HAND_CENTROID_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        object_image, pixel_valid, frame_start;
    logic        feat_valid, frame_abort, hand_present;
    logic [7:0]  min_x, max_x;
    logic [6:0]  min_y, max_y;
    logic [14:0] area;
    logic [21:0] sum_x, sum_y;

    int n_cmp = 0;
    int n_bad = 0;
    int feat_cnt = 0;
    int abort_cnt = 0;

    hand_bbox_extractor #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_AREA(200)) dut (
        .clk          (clk),
        .rst          (rst),
        .object_image (object_image),
        .pixel_valid  (pixel_valid),
        .frame_start  (frame_start),
        .feat_valid   (feat_valid),
        .frame_abort  (frame_abort),
        .hand_present (hand_present),
        .min_x        (min_x),
        .max_x        (max_x),
        .min_y        (min_y),
        .max_y        (max_y),
        .area         (area),
        .sum_x        (sum_x),
        .sum_y        (sum_y)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (feat_valid === 1'b1)  feat_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
    end

    typedef struct {
        int kind;      // 0 empty, 1 single pixel at (10,5), 2 rectangle x40..59 y30..49
        bit gaps;
        bit last_fs;
        int hp, minx, maxx, miny, maxy, ar, sx, sy;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic obj_at(input int kind, input int x, input int y);
        case (kind)
            1:       return (x == 10) && (y == 5);
            2:       return (x >= 40) && (x <= 59) && (y >= 30) && (y <= 49);
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic obj, input logic fs);
        object_image = obj;
        frame_start  = fs;
        pixel_valid  = 1'b1;
        @(posedge clk);
        #1;
        pixel_valid  = 1'b0;
        frame_start  = 1'b0;
        object_image = 1'b0;
    endtask

    // Stalled cycles carry junk on the other inputs, which must be ignored.
    task automatic idle_gaps();
        while ($urandom_range(0, 99) < 30) begin
            pixel_valid  = 1'b0;
            frame_start  = 1'($urandom_range(0, 1));
            object_image = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            frame_start  = 1'b0;
        end
    endtask

    task automatic check_record(input string tag, input vec_t v);
        check({tag, "_hand_present"}, hand_present, v.hp);
        check({tag, "_min_x"}, min_x, v.minx);
        check({tag, "_max_x"}, max_x, v.maxx);
        check({tag, "_min_y"}, min_y, v.miny);
        check({tag, "_max_y"}, max_y, v.maxy);
        check({tag, "_area"}, area, v.ar);
        check({tag, "_sum_x"}, sum_x, v.sx);
        check({tag, "_sum_y"}, sum_y, v.sy);
    endtask

    initial begin
        int fb, ab;
        vec_t single_v;

        tbl[0] = '{0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1'b0, 1'b1, 0, 10, 10, 5, 5, 1, CEN ? 10 : 0, CEN ? 5 : 0};
        tbl[2] = '{2, 1'b0, 1'b0, 1, 40, 59, 30, 49, 400, CEN ? 19800 : 0, CEN ? 15800 : 0};
        tbl[3] = '{2, 1'b1, 1'b0, 1, 40, 59, 30, 49, 400, CEN ? 19800 : 0, CEN ? 15800 : 0};
        single_v = tbl[1];

        rst = 1'b1;
        object_image = 1'b0;
        pixel_valid  = 1'b0;
        frame_start  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_feat_valid", feat_valid, 0);
        check("reset_frame_abort", frame_abort, 0);
        check_record("reset", tbl[0]);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            fb = feat_cnt;
            ab = abort_cnt;
            for (int idx = 0; idx < N; idx++) begin
                if (tbl[i].gaps) idle_gaps();
                drive(obj_at(tbl[i].kind, idx % W, idx / W),
                      (idx == 0) || (tbl[i].last_fs && idx == N - 1));
            end
            check($sformatf("frame%0d_feat_latency", i), feat_valid, 1);
            check_record($sformatf("frame%0d", i), tbl[i]);
            @(posedge clk);
            #1;
            check($sformatf("frame%0d_feat_width", i), feat_valid, 0);
            check($sformatf("frame%0d_feat_count", i), feat_cnt - fb, 1);
            check($sformatf("frame%0d_no_abort", i), abort_cnt - ab, 0);
        end

        // Abort a rectangle frame at pixel 5000, then deliver a complete single-pixel frame.
        fb = feat_cnt;
        ab = abort_cnt;
        for (int idx = 0; idx < 5000; idx++)
            drive(obj_at(2, idx % W, idx / W), idx == 0);
        drive(obj_at(1, 0, 0), 1'b1);
        check("abort_pulse", frame_abort, 1);
        check("abort_no_feat", feat_valid, 0);
        check("abort_held_area", area, 400);
        check("abort_held_present", hand_present, 1);
        for (int idx = 1; idx < N; idx++)
            drive(obj_at(1, idx % W, idx / W), 1'b0);
        check("abort_frame_feat", feat_valid, 1);
        check_record("abort_frame", single_v);
        @(posedge clk);
        #1;
        check("abort_count", abort_cnt - ab, 1);
        check("abort_feat_count", feat_cnt - fb, 1);

        // Asynchronous reset mid-frame, then a frame's worth of pixels without frame_start.
        for (int idx = 0; idx < 3000; idx++)
            drive(obj_at(2, idx % W, idx / W), idx == 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_min_x", min_x, 0);
        check("async_rst_max_y", max_y, 0);
        check("async_rst_area", area, 0);
        check("async_rst_sum_x", sum_x, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fb = feat_cnt;
        for (int idx = 0; idx < N + 50; idx++)
            drive(1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("idle_ignores_feat", feat_cnt - fb, 0);
        check("idle_ignores_area", area, 0);
        check("idle_ignores_present", hand_present, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
